// File: rtl/abc_equiv_monitor_pkg.sv
// Shared types and helpers for the F(A,B,C) equivalence monitor.
package abc_chk_pkg;

  localparam int unsigned NUM_IN_DEF = 3;
  localparam int unsigned COV_W      = 2 ** NUM_IN_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  // Increment v, sticking at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32'd32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/abc_equiv_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; also exposes its next value.
module sat_counter
  import abc_chk_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic [W-1:0] nxt_c
);

  always_comb begin
    nxt_c = cnt;
    if (clr) begin
      nxt_c = '0;
    end else if (inc) begin
      nxt_c = W'(sat_inc(32'(cnt), W));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= nxt_c;
    end
  end

endmodule

// File: rtl/abc_equiv_monitor.sv
// Compares two implementations of F(A,B,C) sample by sample and issues a
// registered PASS/FAIL verdict with counters, coverage map and first failing vector.
module abc_equiv_monitor
  import abc_chk_pkg::*;
#(
  parameter int unsigned NUM_IN       = 3,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned MIN_SAMPLES  = 16,
  parameter int unsigned MAX_MISMATCH = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     sample_en,
  input  logic [NUM_IN-1:0]        in_vec,
  input  logic                     f_a,
  input  logic                     f_b,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [CNT_W-1:0]         sample_cnt,
  output logic [CNT_W-1:0]         mismatch_cnt,
  output logic [(1<<NUM_IN)-1:0]   cov_map,
  output logic                     first_fail_valid,
  output logic [NUM_IN-1:0]        first_fail_vec
);

  localparam int unsigned COVW = 1 << NUM_IN;

  state_t            state;
  logic              clr_c;
  logic              accept_c;
  logic              mis_c;
  logic              fail_c;
  logic              pass_c;
  logic [CNT_W-1:0]  smp_nxt_c;
  logic [CNT_W-1:0]  mis_nxt_c;
  logic [COVW-1:0]   cov_nxt_c;

  // A start only clears outside RUN; samples only count inside RUN.
  assign clr_c    = start && (state != ST_RUN);
  assign accept_c = sample_en && (state == ST_RUN);
  assign mis_c    = accept_c && (f_a != f_b);
  assign cov_nxt_c = cov_map | (accept_c ? (COVW'(1) << in_vec) : '0);

  // Verdicts look at statistics including the current sample; FAIL has priority.
  assign fail_c = mis_c && (mis_nxt_c >= CNT_W'(MAX_MISMATCH));
  assign pass_c = accept_c && !mis_c && (&cov_nxt_c) &&
                  (smp_nxt_c >= CNT_W'(MIN_SAMPLES)) && (mismatch_cnt == '0);

  sat_counter #(.W(CNT_W)) u_sample_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_c),
    .inc   (accept_c),
    .cnt   (sample_cnt),
    .nxt_c (smp_nxt_c)
  );

  sat_counter #(.W(CNT_W)) u_mismatch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_c),
    .inc   (mis_c),
    .cnt   (mismatch_cnt),
    .nxt_c (mis_nxt_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      cov_map          <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else if (clr_c) begin
      state            <= ST_RUN;
      busy             <= 1'b1;
      done             <= 1'b0;
      pass             <= 1'b0;
      cov_map          <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else if (accept_c) begin
      cov_map <= cov_nxt_c;
      if (mis_c && !first_fail_valid) begin
        first_fail_valid <= 1'b1;
        first_fail_vec   <= in_vec;
      end
      if (fail_c) begin
        state <= ST_FAIL;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= 1'b0;
      end else if (pass_c) begin
        state <= ST_PASS;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_abc_equiv_monitor.sv
// Self-checking bench: two monitors (MAX_MISMATCH=1 and 3) on shared stimulus,
// compared against a behavioural model of the run/verdict rules.
module tb_abc_equiv_monitor;

  logic clk, rst_n, start, sample_en, f_a, f_b;
  logic [2:0] in_vec;

  logic        u1_busy, u1_done, u1_pass, u1_ffv;
  logic [15:0] u1_scnt, u1_mcnt;
  logic [7:0]  u1_cov;
  logic [2:0]  u1_ffvec;
  logic        u3_busy, u3_done, u3_pass, u3_ffv;
  logic [15:0] u3_scnt, u3_mcnt;
  logic [7:0]  u3_cov;
  logic [2:0]  u3_ffvec;

  int total = 0;
  int bad   = 0;

  // Model: st 0=idle 1=run 2=pass 3=fail; index 0 -> u1, 1 -> u3.
  int m_st[2], m_s[2], m_m[2], m_cov[2], m_ffv[2], m_ffvec[2];
  int mmax[2] = '{1, 3};

  abc_equiv_monitor #(.NUM_IN(3), .CNT_W(16), .MIN_SAMPLES(16), .MAX_MISMATCH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_en(sample_en), .in_vec(in_vec),
    .f_a(f_a), .f_b(f_b), .busy(u1_busy), .done(u1_done), .pass(u1_pass),
    .sample_cnt(u1_scnt), .mismatch_cnt(u1_mcnt), .cov_map(u1_cov),
    .first_fail_valid(u1_ffv), .first_fail_vec(u1_ffvec));

  abc_equiv_monitor #(.NUM_IN(3), .CNT_W(16), .MIN_SAMPLES(16), .MAX_MISMATCH(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_en(sample_en), .in_vec(in_vec),
    .f_a(f_a), .f_b(f_b), .busy(u3_busy), .done(u3_done), .pass(u3_pass),
    .sample_cnt(u3_scnt), .mismatch_cnt(u3_mcnt), .cov_map(u3_cov),
    .first_fail_valid(u3_ffv), .first_fail_vec(u3_ffvec));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [46:0] obs(input int k);
    if (k == 0) return {u1_busy, u1_done, u1_pass, u1_scnt, u1_mcnt, u1_cov, u1_ffv, u1_ffvec};
    return {u3_busy, u3_done, u3_pass, u3_scnt, u3_mcnt, u3_cov, u3_ffv, u3_ffvec};
  endfunction

  function automatic logic [46:0] exp_vec(input int k);
    return {(m_st[k] == 1), (m_st[k] >= 2), (m_st[k] == 2), 16'(m_s[k]), 16'(m_m[k]),
            8'(m_cov[k]), (m_ffv[k] != 0), 3'(m_ffvec[k])};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_s[k] = 0; m_m[k] = 0; m_cov[k] = 0; m_ffv[k] = 0; m_ffvec[k] = 0;
    end
  endtask

  task automatic model_clock(input logic s, input logic en, input int v, input logic a, input logic b);
    for (int k = 0; k < 2; k++) begin
      if (m_st[k] != 1 && s) begin
        m_st[k] = 1; m_s[k] = 0; m_m[k] = 0; m_cov[k] = 0; m_ffv[k] = 0; m_ffvec[k] = 0;
      end else if (m_st[k] == 1 && en) begin
        if (m_s[k] < 65535) m_s[k]++;
        m_cov[k] = m_cov[k] | (1 << v);
        if (a != b) begin
          if (m_m[k] < 65535) m_m[k]++;
          if (m_ffv[k] == 0) begin m_ffv[k] = 1; m_ffvec[k] = v; end
        end
        if (a != b && m_m[k] >= mmax[k]) m_st[k] = 3;
        else if (a == b && m_cov[k] == 255 && m_s[k] >= 16 && m_m[k] == 0) m_st[k] = 2;
      end
    end
  endtask

  // One clock: drive at negedge, update model at posedge, settle to posedge+1.
  task automatic step(input logic s, input logic en, input int v, input logic a, input logic b);
    @(negedge clk);
    start = s; sample_en = en; in_vec = 3'(v); f_a = a; f_b = b;
    @(posedge clk);
    model_clock(s, en, v, a, b);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 0; sample_en = 0; in_vec = 0; f_a = 0; f_b = 0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic r;
    rst_n = 1'b0; start = 0; sample_en = 0; in_vec = 0; f_a = 0; f_b = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs(k) !== 47'd0) begin
        bad++; $display("FAIL reset_state[%0d] got=%h want=0", k, obs(k));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      r = 1'($urandom);
      step(1'b0, 1'b1, int'($urandom_range(7, 0)), r, ~r);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== exp_vec(k)) begin
          bad++; $display("FAIL idle_ignore[%0d] cyc=%0d got=%h want=%h", k, i, obs(k), exp_vec(k));
        end
      end
    end
  endtask

  task automatic test_exhaustive_pass();
    logic r;
    do_reset();
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      r = 1'($urandom);
      step(1'b0, 1'b1, i % 8, r, r);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== exp_vec(k)) begin
          bad++; $display("FAIL exh_pass[%0d] smp=%0d got=%h want=%h", k, i, obs(k), exp_vec(k));
        end
      end
    end
    total++;
    if ({u1_done, u1_pass, u1_scnt, u1_cov, u1_mcnt} !== {1'b1, 1'b1, 16'd16, 8'hFF, 16'd0}) begin
      bad++; $display("FAIL exh_pass_final got=%b%b %0d %h %0d want=11 16 ff 0",
                      u1_done, u1_pass, u1_scnt, u1_cov, u1_mcnt);
    end
  endtask

  task automatic test_early_fail();
    logic r;
    do_reset();
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      r = 1'($urandom);
      if (i == 3) step(1'b0, 1'b1, 5, 1'b1, 1'b0);
      else        step(1'b0, 1'b1, int'($urandom_range(7, 0)), r, (i > 3) ? ~r : r);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== exp_vec(k)) begin
          bad++; $display("FAIL early_fail[%0d] smp=%0d got=%h want=%h", k, i, obs(k), exp_vec(k));
        end
      end
    end
    total++;
    if ({u1_done, u1_pass, u1_mcnt, u1_ffvec, u1_scnt} !== {1'b1, 1'b0, 16'd1, 3'b101, 16'd4}) begin
      bad++; $display("FAIL early_fail_final got=%b%b m=%0d v=%b s=%0d want=10 m=1 v=101 s=4",
                      u1_done, u1_pass, u1_mcnt, u1_ffvec, u1_scnt);
    end
  endtask

  task automatic test_max3();
    int vecs[6] = '{0, 2, 4, 6, 3, 1};
    do_reset();
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, vecs[i], 1'b0, (i % 2) == 1);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== exp_vec(k)) begin
          bad++; $display("FAIL max3[%0d] smp=%0d got=%h want=%h", k, i, obs(k), exp_vec(k));
        end
      end
      if (i == 3) begin
        total++;
        if ({u3_busy, u3_done} !== 2'b10) begin
          bad++; $display("FAIL max3_not_yet got=%b%b want=10", u3_busy, u3_done);
        end
      end
    end
    total++;
    if ({u3_done, u3_pass, u3_mcnt, u3_ffvec} !== {1'b1, 1'b0, 16'd3, 3'b010}) begin
      bad++; $display("FAIL max3_final got=%b%b m=%0d v=%b want=10 m=3 v=010",
                      u3_done, u3_pass, u3_mcnt, u3_ffvec);
    end
  endtask

  task automatic test_cov_gap();
    logic r;
    do_reset();
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      r = 1'($urandom);
      step(1'b0, 1'b1, i % 7, r, r);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== exp_vec(k)) begin
          bad++; $display("FAIL cov_gap[%0d] smp=%0d got=%h want=%h", k, i, obs(k), exp_vec(k));
        end
      end
    end
    total++;
    if ({u1_busy, u1_cov} !== {1'b1, 8'h7F}) begin
      bad++; $display("FAIL cov_gap_hold got=%b %h want=1 7f", u1_busy, u1_cov);
    end
    step(1'b0, 1'b1, 7, 1'b1, 1'b1);
    total++;
    if ({u1_done, u1_pass, u3_done, u3_pass, u1_scnt} !== {4'b1111, 16'd41}) begin
      bad++; $display("FAIL cov_gap_close got=%b%b%b%b s=%0d want=1111 s=41",
                      u1_done, u1_pass, u3_done, u3_pass, u1_scnt);
    end
  endtask

  task automatic test_restart();
    do_reset();
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 6, 1'b0, 1'b1);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    total++;
    if ({u1_busy, u1_done, u1_scnt, u1_mcnt, u1_ffv} !== {2'b10, 16'd0, 16'd0, 1'b0}) begin
      bad++; $display("FAIL restart_clear got=%b%b s=%0d m=%0d f=%b want=10 0 0 0",
                      u1_busy, u1_done, u1_scnt, u1_mcnt, u1_ffv);
    end
    step(1'b1, 1'b1, 3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs(k) !== exp_vec(k)) begin
        bad++; $display("FAIL restart_run[%0d] got=%h want=%h", k, obs(k), exp_vec(k));
      end
    end
    // Asynchronous reset between edges.
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (obs(k) !== 47'd0) begin
        bad++; $display("FAIL async_reset[%0d] got=%h want=0", k, obs(k));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 2, 1'b0, 1'b1);
    total++;
    if ({u1_busy, u1_scnt, u1_mcnt, u1_cov} !== {1'b1, 16'd0, 16'd0, 8'h00}) begin
      bad++; $display("FAIL start_drop got=%b s=%0d m=%0d c=%h want=1 0 0 00",
                      u1_busy, u1_scnt, u1_mcnt, u1_cov);
    end
  endtask

  task automatic test_random();
    logic s, en, a, b;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      s  = ($urandom % 20) == 0;
      en = ($urandom % 4) != 0;
      a  = 1'($urandom);
      b  = (($urandom % 16) == 0) ? ~a : a;
      step(s, en, int'($urandom_range(7, 0)), a, b);
      for (int k = 0; k < 2; k++) begin
        total++;
        if (obs(k) !== exp_vec(k)) begin
          bad++; $display("FAIL random[%0d] cyc=%0d got=%h want=%h", k, i, obs(k), exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_exhaustive_pass();
    test_early_fail();
    test_max3();
    test_cov_gap();
    test_restart();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/abc_equiv_monitor.md
Name: abc_equiv_monitor

Overview:
- Downstream consumer of the two F(A,B,C) implementations (variants "a" and "b") driven by the same A/B/C stimulus.
- Each enabled cycle it samples the input vector and both outputs, counts samples and mismatches, and builds an input-coverage bitmap.
- It captures the first failing vector and ends the run with a registered PASS/FAIL verdict.
- It is synthesizable, so it can also serve as an on-chip self-check.

Parameters:
- NUM_IN, 3, width of input vector {A,B,C}; coverage map has 2**NUM_IN bits.
- CNT_W, 16, width of sample and mismatch counters.
- MIN_SAMPLES, 16, minimum samples required before PASS may be declared.
- MAX_MISMATCH, 1, mismatch count that forces FAIL (range 1..2**CNT_W-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: clear statistics and begin a run.
- sample_en  in  1  the in_vec/f_a/f_b values on this cycle are valid.
- in_vec  in  NUM_IN  stimulus vector, MSB=A, LSB=C.
- f_a  in  1  output of implementation a.
- f_b  in  1  output of implementation b.
- busy  out  1  state is RUN.
- done  out  1  state is PASS or FAIL (level).
- pass  out  1  state is PASS.
- sample_cnt  out  CNT_W  samples accepted this run, saturating.
- mismatch_cnt  out  CNT_W  samples with f_a!=f_b, saturating.
- cov_map  out  2**NUM_IN  bit i set once in_vec==i has been sampled.
- first_fail_valid  out  1  first_fail_vec holds a captured vector.
- first_fail_vec  out  NUM_IN  in_vec of the first mismatching sample.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - State is IDLE.
  - All outputs are 0, all counters 0, cov_map 0, first_fail_* 0.
- States:
  - IDLE: waits for start; sample_en is ignored.
  - IDLE --start--> RUN: the same edge clears counters, cov_map and first_fail_*.
  - RUN: on each sample_en cycle:
    - sample_cnt += 1 (saturating at 2**CNT_W-1).
    - cov_map[in_vec] <= 1.
    - If f_a!=f_b: mismatch_cnt += 1 (saturating). If first_fail_valid==0, capture first_fail_vec<=in_vec and set first_fail_valid.
  - RUN -> FAIL: when the mismatch count including the current sample reaches MAX_MISMATCH.
  - RUN -> PASS: when, on a sample_en cycle with no mismatch, cov_map including the current sample is all ones, sample_cnt including the current sample is >= MIN_SAMPLES, and mismatch_cnt==0.
  - PASS/FAIL: hold all statistics; sample_en is ignored. A start pulse clears and re-enters RUN, same as from IDLE.
- Latency: every output is registered. The effect of a sample on cycle N is visible after the edge that ends cycle N. The verdict (done/pass) asserts on that same edge.
- Comparison is 2-state. X/Z behaviour on f_a/f_b is not defined for RTL; the bench must drive known values.
- Simultaneous events:
  - start together with sample_en in IDLE/PASS/FAIL: the clear wins and the sample is dropped.
  - start during RUN: ignored, the run continues.
  - Mismatch on the same sample that completes coverage: FAIL wins.
- Saturation: counters stick at max and never wrap. The verdict logic uses the saturated values.
- Reset asserted mid-run: immediate return to IDLE with all outputs cleared. No partial verdict survives.

Decomposition:
- Shared package abc_chk_pkg:
  - state enum (IDLE, RUN, PASS, FAIL) as 2-bit encoding.
  - COV_W = 2**NUM_IN default constant.
  - saturating-increment function.
- One natural sub-module: sat_counter (parameterised width, clear, inc; the saturating counter), instantiated twice.
- Coverage map and first-fail capture stay in the top.

Test Plan:
- Reset/idle: rst_n low 3 cycles, then sample_en=1 without start for 5 cycles -> all outputs 0, state IDLE.
- Exhaustive pass: start, then in_vec 0..7 twice (16 samples) with f_a==f_b -> after the 16th sample done=1, pass=1, sample_cnt=16, cov_map=8'hFF, mismatch_cnt=0.
- Early fail: start, then in_vec=3'b101 with f_a=1, f_b=0 as the 4th sample -> done=1, pass=0, mismatch_cnt=1, first_fail_vec=3'b101, sample_cnt=4, later samples ignored.
- MAX_MISMATCH=3: mismatches at vectors 2, 6, 1 -> FAIL only after the third mismatch; first_fail_vec=3'b010; mismatch_cnt=3.
- Coverage gap: 40 matching samples never using in_vec=7 -> still busy=1, cov_map=8'h7F; then in_vec=7 -> PASS on that edge.
- Restart/reset: after FAIL, start -> counters clear, busy=1. Mid-run rst_n low -> all outputs 0 immediately (async). Also check start+sample_en same cycle -> sample_cnt=0 after that edge.
